spiadc_seq: RTL and testbench
=============================

SPIADC_SEQ -- requirements
Module: spiadc_seq

Interface
REQ-001 The module SHALL have the following parameters (name, default, meaning):
- NCH, 2: MISO lanes sharing one CSn/SCK, 1..8.
- DW, 12: data bits kept per lane.
- LEAD, 4: leading bits discarded per frame; frame length is LEAD+DW bits.
- CKPCK, 2: SCK half-period is CKPCK+1 i_clk cycles.
- QUIET, 4: minimum CSn-high cycles between frames.
- LGFIFO, 4: log2 of the FIFO depth.
REQ-002 The module SHALL have the following ports (name, direction, width, meaning):
- i_clk, in, 1: the single clock.
- i_reset_n, in, 1: asynchronous, active-low reset.
- i_en, in, 1: enables new frames.
- i_cont, in, 1: selects continuous (timer-paced) mode.
- i_request, in, 1: single-shot start pulse.
- i_interval, in, 16: continuous-mode sample period minus 1, in i_clk cycles.
- o_csn, out, 1: ADC chip select, active low.
- o_sck, out, 1: SPI clock, idles high.
- i_miso, in, NCH: serial data, one bit per lane.
- o_valid, out, 1: FIFO head is valid.
- i_ready, in, 1: consumer accepts the head.
- o_data, out, NCH*DW: FIFO head; lane 0 in the LSBs.
- o_fill, out, LGFIFO+1: FIFO occupancy.
- o_overflow, out, 1: sticky overflow flag.
- i_clr_ovfl, in, 1: clears o_overflow.
- o_busy, out, 1: high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have three states: IDLE, SHIFT and QUIET.
REQ-004 In IDLE, o_csn and o_sck SHALL both be 1.
REQ-005 IDLE SHALL go to SHIFT when i_en && (i_request || (i_cont && timer==0)).
REQ-006 i_request SHALL be ignored outside IDLE and SHALL NOT be queued.
REQ-007 In SHIFT, o_csn SHALL be 0 and o_sck SHALL toggle every CKPCK+1 cycles, starting high.
REQ-008 The first falling edge of o_sck SHALL occur CKPCK+1 cycles after o_csn falls.
REQ-009 Each lane SHALL shift in i_miso[n] in the cycle o_sck goes 0->1.
REQ-010 After the (LEAD+DW)th rising edge, o_sck SHALL stay high and the next cycle SHALL raise o_csn and enter QUIET.
REQ-011 Total o_csn low time SHALL be 2*(CKPCK+1)*(LEAD+DW)+1 cycles (97 with defaults).
REQ-012 In the cycle o_csn rises, the low DW bits of every lane SHALL be pushed into the FIFO as one NCH*DW word, MSB-first per lane.
REQ-013 QUIET SHALL hold o_csn=1 for exactly QUIET cycles and then return to IDLE.
REQ-014 The 16-bit timer SHALL load i_interval at each SHIFT entry and decrement to 0 and hold.
REQ-015 Frame spacing SHALL be max(i_interval+1, frame+QUIET cycles); i_interval changes SHALL take effect at the next load.
REQ-016 Deasserting i_en mid-frame SHALL let the frame complete and push normally, and no further frames SHALL start.
REQ-017 The FIFO SHALL be show-ahead with depth 2^LGFIFO.
REQ-018 o_valid SHALL equal (o_fill!=0); a pop SHALL occur on o_valid && i_ready.
REQ-019 A push while full with no pop in the same cycle SHALL be discarded and SHALL set o_overflow.
REQ-020 A push and a pop in the same cycle while full SHALL both take effect, with no overflow.
REQ-021 A push and a pop in the same cycle while empty SHALL leave fill at 1 with o_valid asserted the next cycle.
REQ-022 o_overflow SHALL clear on i_clr_ovfl; if an overflow occurs in the same cycle, set SHALL win.
REQ-023 The FIFO pointers SHALL wrap modulo 2^LGFIFO, and o_fill SHALL never exceed 2^LGFIFO.

Reset
REQ-024 While i_reset_n=0, immediately and independent of i_clk, the block SHALL drive: state IDLE, o_csn=1, o_sck=1, o_busy=0, timer=0, lane shift registers 0, FIFO pointers 0, o_fill=0, o_valid=0 and o_overflow=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame without a push.
REQ-026 After reset release, the first frame SHALL require a new start condition.

Verification
REQ-027 Defaults, one i_request, lane0 stream 16'h0ABC, lane1 stream 16'h0123 -> o_csn low 97 cycles, 16 SCK rising edges, o_data=24'h123ABC, and o_valid high the cycle after o_csn rises.
REQ-028 i_cont=1, i_interval=199 -> o_csn falling edges exactly 200 cycles apart; with i_interval=10 -> spacing 101 cycles (97+4).
REQ-029 LGFIFO=2, i_ready=0, 5 frames -> o_fill=4, o_overflow=1, head=first sample; after i_clr_ovfl, o_overflow=0.
REQ-030 FIFO full and i_ready=1 held on the push cycle -> o_fill stays 4, no overflow, and the newest sample is in the FIFO tail.
REQ-031 i_en dropped at bit 5 of a frame -> that frame completes and pushes, and o_csn stays high afterwards.
REQ-032 i_reset_n pulsed low at bit 8 of a frame -> o_csn=1 and o_sck=1 within the same cycle, o_fill=0, and no push.

Source files
------------

// File: rtl/spiadc_seq.sv
// Multi-lane SPI ADC sequencer: frames CSn/SCK, shifts NCH MISO lanes in
// parallel and queues each frame's samples in a show-ahead FIFO.
module spiadc_seq #(
  parameter int NCH    = 2,
  parameter int DW     = 12,
  parameter int LEAD   = 4,
  parameter int CKPCK  = 2,
  parameter int QUIET  = 4,
  parameter int LGFIFO = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_en,
  input  logic                  i_cont,
  input  logic                  i_request,
  input  logic [15:0]           i_interval,
  output logic                  o_csn,
  output logic                  o_sck,
  input  logic [NCH-1:0]        i_miso,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [NCH*DW-1:0]     o_data,
  output logic [LGFIFO:0]       o_fill,
  output logic                  o_overflow,
  input  logic                  i_clr_ovfl,
  output logic                  o_busy
);

  localparam int FRAME = LEAD + DW;
  localparam int DEPTH = 1 << LGFIFO;
  localparam int FW    = LGFIFO + 1;
  localparam int BW    = $clog2(FRAME + 1);
  localparam int CW    = $clog2(CKPCK + 2);
  localparam int QW    = $clog2(QUIET + 2);
  // The IDLE decision cycle also holds CSn high, so QUIET state itself
  // lasts one cycle less to keep back-to-back spacing at frame+QUIET.
  localparam int QLOAD = (QUIET > 1) ? QUIET - 2 : 0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_QUIET = 2'd2;

  logic [1:0]               state;
  logic [CW-1:0]            hcnt;
  logic [BW-1:0]            bitcnt;
  logic [QW-1:0]            qcnt;
  logic [15:0]              timer;
  logic [NCH-1:0][DW-1:0]   sr;
  logic                     push_p0;
  logic                     start;

  logic [NCH*DW-1:0]        mem [DEPTH];
  logic [LGFIFO-1:0]        wptr;
  logic [LGFIFO-1:0]        rptr;
  logic                     pop;
  logic                     full;
  logic                     wr_en;

  assign start  = i_en && (i_request || (i_cont && (timer == 16'd0)));
  assign o_busy = (state != S_IDLE);

  // Stage p0: sequencer and lane shifters; push_p0 marks the first CSn-high cycle
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= S_IDLE;
      o_csn   <= 1'b1;
      o_sck   <= 1'b1;
      hcnt    <= '0;
      bitcnt  <= '0;
      qcnt    <= '0;
      timer   <= '0;
      sr      <= '0;
      push_p0 <= 1'b0;
    end else begin
      push_p0 <= 1'b0;
      if (timer != 16'd0)
        timer <= timer - 16'd1;
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_SHIFT;
            o_csn  <= 1'b0;
            o_sck  <= 1'b1;
            hcnt   <= CW'(CKPCK);
            bitcnt <= '0;
            timer  <= i_interval;
          end
        end
        S_SHIFT: begin
          if (o_sck && (bitcnt == BW'(FRAME))) begin
            state   <= S_QUIET;
            o_csn   <= 1'b1;
            push_p0 <= 1'b1;
            qcnt    <= QW'(QLOAD);
          end else if (hcnt != '0) begin
            hcnt <= hcnt - CW'(1);
          end else begin
            hcnt  <= CW'(CKPCK);
            o_sck <= ~o_sck;
            if (!o_sck) begin
              bitcnt <= bitcnt + BW'(1);
              for (int n = 0; n < NCH; n++)
                sr[n] <= {sr[n][DW-2:0], i_miso[n]};
            end
          end
        end
        S_QUIET: begin
          if (qcnt == '0)
            state <= S_IDLE;
          else
            qcnt <= qcnt - QW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pop     = o_valid && i_ready;
  assign full    = (o_fill == FW'(DEPTH));
  assign wr_en   = push_p0 && (!full || pop);
  assign o_valid = (o_fill != '0);
  assign o_data  = mem[rptr];

  // Stage p1: FIFO storage; shift registers hold steady during the push cycle
  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[wptr] <= sr;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      o_fill     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (wr_en)
        wptr <= wptr + LGFIFO'(1);
      if (pop)
        rptr <= rptr + LGFIFO'(1);
      if (wr_en && !pop)
        o_fill <= o_fill + FW'(1);
      else if (pop && !wr_en)
        o_fill <= o_fill - FW'(1);
      if (push_p0 && full && !pop)
        o_overflow <= 1'b1;
      else if (i_clr_ovfl)
        o_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spiadc_seq.sv
// Bench for spiadc_seq: ADC lane model plus a queue-based FIFO reference,
// driven through a linear sequence of directed and randomized steps.
module tb_spiadc_seq;

  localparam int NCH     = 2;
  localparam int DW      = 12;
  localparam int LEAD    = 4;
  localparam int CKPCK   = 2;
  localparam int QUIET   = 4;
  localparam int LGFIFO  = 2;
  localparam int FRAME   = LEAD + DW;
  localparam int DEPTH   = 1 << LGFIFO;
  localparam int LOWLEN  = 2 * (CKPCK + 1) * FRAME + 1;
  localparam int MINSPC  = LOWLEN + QUIET;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                en = 1'b0;
  logic                cont = 1'b0;
  logic                request = 1'b0;
  logic [15:0]         interval = 16'd0;
  logic [NCH-1:0]      miso = '0;
  logic                ready = 1'b0;
  logic                clr = 1'b0;
  logic                csn, sck, valid, ovfl, busy;
  logic [NCH*DW-1:0]   data;
  logic [LGFIFO:0]     fill;

  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          frames = 0;
  int          rises = 0;
  int          low_len = 0;
  bit          in_frame = 0;
  bit          prev_csn = 1;
  bit          prev_sck = 1;
  bit          m_ovfl = 0;
  bit          use_fixed = 0;
  logic [15:0] fixed_w [NCH];
  logic [15:0] cur_w [NCH];
  logic [63:0] exp_q [$];
  int          falls [$];
  logic [63:0] last_word = '0;

  spiadc_seq #(
    .NCH(NCH), .DW(DW), .LEAD(LEAD), .CKPCK(CKPCK), .QUIET(QUIET), .LGFIFO(LGFIFO)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_cont(cont), .i_request(request),
    .i_interval(interval), .o_csn(csn), .o_sck(sck), .i_miso(miso), .o_valid(valid),
    .i_ready(ready), .o_data(data), .o_fill(fill), .o_overflow(ovfl),
    .i_clr_ovfl(clr), .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ADC lanes and FIFO reference, evaluated once per cycle on the falling edge
  always @(negedge clk) begin
    logic [63:0] w;
    bit ovf_now;
    if (!rst_n) begin
      exp_q.delete();
      m_ovfl   = 0;
      in_frame = 0;
      rises    = 0;
      prev_csn = 1;
      prev_sck = 1;
      miso     = '0;
    end else begin
      ovf_now = 0;
      check("fill", 64'(fill), 64'(exp_q.size()));
      check("valid", 64'(valid), 64'(exp_q.size() != 0));
      check("overflow", 64'(ovfl), 64'(m_ovfl));
      if (csn) check("sck_idle_high", 64'(sck), 64'(1));
      if (ready && exp_q.size() != 0) begin
        check("pop_data", 64'(data), exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (in_frame && !prev_sck && sck) rises++;
      if (prev_csn && !csn) begin
        in_frame = 1;
        rises    = 0;
        low_len  = 0;
        falls.push_back(cyc);
        for (int l = 0; l < NCH; l++)
          cur_w[l] = use_fixed ? fixed_w[l] : 16'($urandom_range(0, 65535));
      end
      if (!csn) low_len++;
      if (!prev_csn && csn && in_frame) begin
        in_frame = 0;
        frames++;
        check("csn_low_cycles", 64'(low_len), 64'(LOWLEN));
        check("sck_rises", 64'(rises), 64'(FRAME));
        w = '0;
        for (int l = 0; l < NCH; l++)
          w = w | (64'(cur_w[l] % (1 << DW)) << (l * DW));
        last_word = w;
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else begin
          m_ovfl  = 1;
          ovf_now = 1;
        end
      end
      if (clr && !ovf_now) m_ovfl = 0;
      for (int l = 0; l < NCH; l++)
        miso[l] = (in_frame && rises < FRAME) ? cur_w[l][FRAME-1-rises] : 1'b0;
      prev_csn = csn;
      prev_sck = sck;
    end
  end

  task automatic pulse_req();
    @(posedge clk); #1 request = 1'b1;
    @(posedge clk); #1 request = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frames < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (frames < n) check("timeout_frames", 64'(frames), 64'(n));
  endtask

  task automatic wait_bit(input int b, input int budget);
    int k = 0;
    while (!(in_frame && rises == b) && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (!(in_frame && rises == b)) check("timeout_bit", 64'(rises), 64'(b));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int fb;
    logic [63:0] first_word, newest, tail;
    fixed_w[0] = 16'h0;
    fixed_w[1] = 16'h0;

    // reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_csn", 64'(csn), 64'(1));
    check("rst_sck", 64'(sck), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_fill", 64'(fill), 64'(0));
    check("rst_valid", 64'(valid), 64'(0));
    check("rst_ovfl", 64'(ovfl), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    en = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("idle_no_start", 64'(csn), 64'(1));

    // one request with known lane streams; a second request mid-frame is dropped
    use_fixed  = 1;
    fixed_w[0] = 16'h0ABC;
    fixed_w[1] = 16'h0123;
    pulse_req();
    repeat (20) @(posedge clk);
    #1 check("busy_in_frame", 64'(busy), 64'(1));
    pulse_req();
    wait_frames(1, 400);
    use_fixed = 0;
    @(negedge clk);
    check("valid_after_push", 64'(valid), 64'(1));
    check("first_data", 64'(data), 64'(24'h123ABC));
    repeat (150) @(posedge clk);
    check("request_not_queued", 64'(frames), 64'(1));

    // random lane data with a randomly stalling consumer
    for (int k = 0; k < 3; k++) begin
      pulse_req();
      for (int c = 0; c < 400 && frames < 2 + k; c++) begin
        @(posedge clk);
        #1 ready = 1'($urandom_range(0, 1));
      end
      check("rand_frame_done", 64'(frames), 64'(2 + k));
      repeat (6) @(posedge clk);
    end
    #1 ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("drained", 64'(fill), 64'(0));

    // continuous mode pacing and interval change at next load
    falls.delete();
    @(posedge clk); #1 interval = 16'd199; cont = 1'b1;
    for (int c = 0; c < 2000 && falls.size() < 3; c++) @(posedge clk);
    #1 interval = 16'd10;
    for (int c = 0; c < 2000 && falls.size() < 6; c++) @(posedge clk);
    #1 cont = 1'b0;
    repeat (150) @(posedge clk);
    check("cont_fall_count", 64'(falls.size()), 64'(6));
    for (int i = 1; i < 6; i++)
      check("cont_spacing", 64'(falls[i] - falls[i-1]), 64'((i <= 3) ? 200 : MINSPC));

    // enable dropped mid-frame: frame completes, nothing further starts
    fb = frames;
    @(posedge clk); #1 interval = 16'd0; cont = 1'b1;
    wait_bit(5, 400);
    #1 en = 1'b0;
    wait_frames(fb + 1, 400);
    repeat (200) @(posedge clk);
    #1;
    check("en_drop_frames", 64'(frames), 64'(fb + 1));
    check("en_drop_csn", 64'(csn), 64'(1));
    check("en_drop_busy", 64'(busy), 64'(0));
    cont = 1'b0;
    en   = 1'b1;

    // overflow with a stalled consumer
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk);
    check("pre_ovfl_empty", 64'(fill), 64'(0));
    fb = frames;
    first_word = '0;
    for (int k = 0; k < 5; k++) begin
      pulse_req();
      wait_frames(fb + k + 1, 400);
      if (k == 0) first_word = last_word;
      repeat (6) @(posedge clk);
    end
    @(negedge clk);
    check("ovfl_fill", 64'(fill), 64'(DEPTH));
    check("ovfl_flag", 64'(ovfl), 64'(1));
    check("ovfl_head", 64'(data), first_word);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    check("ovfl_cleared", 64'(ovfl), 64'(0));
    @(posedge clk); #1 clr = 1'b1;
    pulse_req();
    wait_bit(FRAME, 400);
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    check("ovfl_set_wins", 64'(ovfl), 64'(1));
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    repeat (6) @(posedge clk);

    // push and pop together while full
    pulse_req();
    wait_bit(FRAME, 400);
    #1 ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk);
    check("full_pushpop_fill", 64'(fill), 64'(DEPTH));
    check("full_pushpop_ovfl", 64'(ovfl), 64'(0));
    newest = last_word;
    tail = '0;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1 ready = 1'b1;
      @(negedge clk);
      tail = 64'(data);
    end
    @(posedge clk); #1 ready = 1'b0;
    check("full_pushpop_tail", tail, newest);
    @(negedge clk);
    check("full_drained", 64'(fill), 64'(0));

    // reset mid-frame aborts it and clears the queue
    fb = frames;
    pulse_req();
    wait_frames(fb + 1, 400);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("pre_reset_fill", 64'(fill), 64'(1));
    fb = frames;
    pulse_req();
    wait_bit(8, 400);
    #2 rst_n = 1'b0;
    #1;
    check("abort_csn", 64'(csn), 64'(1));
    check("abort_sck", 64'(sck), 64'(1));
    check("abort_fill", 64'(fill), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    check("abort_no_push", 64'(frames), 64'(fb));
    check("abort_idle_csn", 64'(csn), 64'(1));
    check("abort_fill_after", 64'(fill), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
